// File: rtl/regfile_pkg.sv
// Shared widths and architectural register indices for the MIPS register file.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file.sv
// 32 x 32 MIPS register file: two combinational read ports, one clocked write port,
// $0 hardwired to zero, $v0/$a0 exported for syscall observation.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WE,
  input  logic [ADDR_W-1:0] reg1_addr,
  input  logic [ADDR_W-1:0] reg2_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] reg1_data,
  output logic [DATA_W-1:0] reg2_data,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] v0
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Entry 0 has no storage; the read function returns zero for it.
  logic [DATA_W-1:0] regs [1:DEPTH-1];

  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
    if (addr == ADDR_W'(REG_ZERO)) begin
      read_reg = '0;
    end else begin
      read_reg = regs[addr];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (WE && (write_addr != ADDR_W'(REG_ZERO))) begin
      regs[write_addr] <= write_data;
    end
  end

  always_comb begin
    reg1_data = read_reg(reg1_addr);
    reg2_data = read_reg(reg2_addr);
  end

  assign a0 = regs[REG_A0];
  assign v0 = regs[REG_V0];

endmodule

// File: tb/tb_register_file.sv
// Randomized scoreboard bench for register_file against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        WE;
  logic [4:0]  reg1_addr;
  logic [4:0]  reg2_addr;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] reg1_data;
  logic [31:0] reg2_data;
  logic [31:0] a0;
  logic [31:0] v0;

  register_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .WE         (WE),
    .reg1_addr  (reg1_addr),
    .reg2_addr  (reg2_addr),
    .write_addr (write_addr),
    .write_data (write_data),
    .reg1_data  (reg1_data),
    .reg2_data  (reg2_data),
    .a0         (a0),
    .v0         (v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] a0;
    logic [31:0] v0;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  logic        pend_we = 1'b0;
  logic [4:0]  pend_wa = '0;
  logic [31:0] pend_wd = '0;

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (reg1_data !== e.r1 || reg2_data !== e.r2 || a0 !== e.a0 || v0 !== e.v0) begin
        errors++;
        $display("FAIL %s: got r1=%h r2=%h a0=%h v0=%h, expected r1=%h r2=%h a0=%h v0=%h",
                 e.tag, reg1_data, reg2_data, a0, v0, e.r1, e.r2, e.a0, e.v0);
      end
    end
  end

  // One cycle of stimulus: retire the previous cycle's write into the model at the edge,
  // then drive new inputs and push what the outputs must show before the next edge.
  task automatic step(input logic rst_val, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input string tag);
    exp_t e;
    @(posedge clk);
    if (rst_n && pend_we && pend_wa != 5'd0) model[pend_wa] = pend_wd;
    #1;
    rst_n      = rst_val;
    WE         = we;
    write_addr = wa;
    write_data = wd;
    reg1_addr  = a1;
    reg2_addr  = a2;
    if (!rst_val) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end
    pend_we = we;
    pend_wa = wa;
    pend_wd = wd;
    e.tag = tag;
    e.r1  = model[a1];
    e.r2  = model[a2];
    e.a0  = model[4];
    e.v0  = model[2];
    sb_q.push_back(e);
  endtask

  task automatic random_steps(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; WE = 1'b0; write_addr = '0; write_data = '0;
    reg1_addr = '0; reg2_addr = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, "reset_state");
    step(1'b0, 1'b1, 5'd3, 32'h55AA55AA, 5'd3, 5'd2, "write_in_reset");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, "reset_release");

    step(1'b1, 1'b1, 5'd2, 32'h12345678, 5'd2, 5'd2, "write_v0_pre");
    step(1'b1, 1'b1, 5'd4, 32'hABCDEF01, 5'd2, 5'd2, "write_v0_post");
    step(1'b1, 1'b0, 5'd4, 32'h0, 5'd2, 5'd4, "read_v0_a0");
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd4, "write_zero_pre");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd2, "zero_protect");
    step(1'b1, 1'b0, 5'd2, 32'hDEADBEEF, 5'd2, 5'd0, "we_low_write");
    step(1'b1, 1'b1, 5'd2, 32'hDEADBEEF, 5'd2, 5'd2, "rdw_old_value");
    step(1'b1, 1'b0, 5'd2, 32'h0, 5'd2, 5'd4, "rdw_new_value");

    for (int i = 1; i < 32; i++) begin
      step(1'b1, 1'b1, 5'(i), 32'hA5A50000 + 32'(i), 5'(i), 5'(32 - i), "sweep_write");
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 5'(i), 32'hFFFF0000, 5'(i), 5'((i * 7) % 32), "sweep_read");
    end
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd17, 5'd17, "same_reg_both_ports");

    random_steps(300, "random_a");

    step(1'b0, 1'b1, 5'd5, 32'h0BADF00D, 5'd2, 5'd4, "midrun_reset");
    step(1'b0, 1'b1, 5'd2, 32'h0BADF00D, 5'd5, 5'd2, "midrun_reset_hold");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "post_reset_zero");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd29, 5'd4, "post_reset_zero2");

    random_steps(200, "random_b");

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
